serial_gate_reducer: RTL and testbench

- Bit-serial front stage for the single-bit gate blocks (mux-built AND and its siblings).
- Accepts a packet of 1-bit operands over a valid/ready/last stream and reduces them with a selectable gate: AND, OR, XOR or NAND.
- Presents one result bit per packet, with beat count and overflow flag, on a valid/ready output held until consumed.
- Accumulator update is a 2:1 mux per op; the AND path is sel = acc, d0 = 0, d1 = data.

---
 rtl/serial_gate_reducer_if.sv | 26 ++
 rtl/serial_gate_reducer.sv | 102 ++++++++++
 tb/tb_serial_gate_reducer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/serial_gate_reducer_if.sv
// Stream bundle for serial_gate_reducer: operand beats upstream, one reduced result downstream.
interface serial_gate_reducer_if #(
    parameter int unsigned MAX_LEN = 16,
    localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1)
);
    logic [1:0]       op;
    logic             up_valid;
    logic             up_ready;
    logic             up_data;
    logic             up_last;
    logic             down_valid;
    logic             down_ready;
    logic             down_result;
    logic [CNT_W-1:0] down_count;
    logic             down_overflow;

    modport slave (
        input  op, up_valid, up_data, up_last, down_ready,
        output up_ready, down_valid, down_result, down_count, down_overflow
    );

    modport master (
        output op, up_valid, up_data, up_last, down_ready,
        input  up_ready, down_valid, down_result, down_count, down_overflow
    );
endinterface

// File: rtl/serial_gate_reducer.sv
// Bit-serial gate reducer: folds a packet of 1-bit operands with AND/OR/XOR/NAND and
// presents one result bit plus saturating beat count and overflow flag.
module serial_gate_reducer #(
    parameter int unsigned MAX_LEN = 16,
    localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_gate_reducer_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e           r_state, w_state_next;
    logic [1:0]       r_op, w_op_next;
    logic             r_acc, w_acc_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             r_ovf, w_ovf_next;
    logic             r_res;
    logic [CNT_W-1:0] r_res_count;
    logic             r_res_ovf;
    logic             w_up_ready;
    logic             w_beat;
    logic             w_res_next;

    assign w_beat = bus.up_valid && w_up_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_beat) w_state_next = bus.up_last ? StHold : StAccum;
            StAccum: if (w_beat && bus.up_last) w_state_next = StHold;
            StHold:  if (bus.down_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_up_ready        = (r_state != StHold);
        bus.up_ready      = w_up_ready;
        bus.down_valid    = (r_state == StHold);
        bus.down_result   = r_res;
        bus.down_count    = r_res_count;
        bus.down_overflow = r_res_ovf;
    end

    // Each op is a 2:1 mux on the accumulator; NAND folds as AND and inverts only at output.
    always_comb begin
        w_op_next    = r_op;
        w_acc_next   = r_acc;
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        if (r_state == StIdle) begin
            w_op_next    = bus.op;
            w_acc_next   = bus.up_data;
            w_count_next = CNT_W'(1);
            w_ovf_next   = (MAX_LEN < 1);
        end else begin
            unique case (r_op)
                2'b01:   w_acc_next = r_acc ? 1'b1 : bus.up_data;
                2'b10:   w_acc_next = r_acc ? ~bus.up_data : bus.up_data;
                default: w_acc_next = r_acc ? bus.up_data : 1'b0;
            endcase
            if (r_count < CNT_W'(MAX_LEN)) begin
                w_count_next = r_count + CNT_W'(1);
            end else begin
                w_ovf_next = 1'b1;
            end
        end
        w_res_next = (w_op_next == 2'b11) ? ~w_acc_next : w_acc_next;
    end

    // Result registers load only on the last beat so outputs stay put outside HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 2'b00;
            r_acc       <= 1'b0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_res       <= 1'b0;
            r_res_count <= '0;
            r_res_ovf   <= 1'b0;
        end else if (w_beat) begin
            r_op    <= w_op_next;
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            if (bus.up_last) begin
                r_res       <= w_res_next;
                r_res_count <= w_count_next;
                r_res_ovf   <= w_ovf_next;
            end
        end
    end
endmodule

// File: tb/tb_serial_gate_reducer.sv
// Directed bench for serial_gate_reducer with a queue-based result scoreboard.
module tb_serial_gate_reducer;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic             res;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    exp_t exp_q[$];

    serial_gate_reducer_if #(.MAX_LEN(MAX_LEN)) bus ();

    serial_gate_reducer #(.MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input int c, input logic o);
        exp_t e;
        e.res = r;
        e.cnt = CNT_W'(c);
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Monitor: a result transfers at the next rising edge when valid and ready are both high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.down_valid && bus.down_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_result: got res=%0b cnt=%0d, expected none",
                             bus.down_result, bus.down_count);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(bus.down_result), 32'(e.res));
                    check("count", 32'(bus.down_count), 32'(e.cnt));
                    check("overflow", 32'(bus.down_overflow), 32'(e.ovf));
                end
            end
        end
    end

    // Beat i carries data[i]; first beat uses op0, later beats drive opr (must be ignored).
    task automatic send_pkt(input logic [1:0] op0, input logic [1:0] opr, input logic [31:0] data,
                            input int n, input int gap, input bit term);
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            bus.up_valid = 1'b1;
            bus.up_data  = data[i];
            bus.up_last  = term && (i == n - 1);
            bus.op       = (i == 0) ? op0 : opr;
            forever begin
                @(negedge clk);
                if (bus.up_ready) break;
                waited++;
                if (waited > 100) begin
                    $display("FAIL beat_accept_timeout: got no up_ready, expected up_ready");
                    $fatal(1, "stalled");
                end
            end
            @(posedge clk);
            #1;
            bus.up_valid = 1'b0;
            bus.up_last  = 1'b1;
            bus.up_data  = ~bus.up_data;
            if (i != n - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus.up_last = 1'b0;
        if (term) begin
            @(negedge clk);
            check("latency_valid", 32'(bus.down_valid), 32'd1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        rst            = 1'b1;
        bus.op         = 2'b00;
        bus.up_valid   = 1'b0;
        bus.up_data    = 1'b0;
        bus.up_last    = 1'b0;
        bus.down_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_up_ready", 32'(bus.up_ready), 32'd1);
        check("rst_down_valid", 32'(bus.down_valid), 32'd0);
        check("rst_result", 32'(bus.down_result), 32'd0);
        check("rst_count", 32'(bus.down_count), 32'd0);
        check("rst_overflow", 32'(bus.down_overflow), 32'd0);
        @(posedge clk);
        #1;

        push(1'b1, 4, 1'b0); send_pkt(2'b00, 2'b00, 32'hF, 4, 0, 1'b1); drain();
        push(1'b0, 3, 1'b0); send_pkt(2'b00, 2'b00, 32'b101, 3, 0, 1'b1); drain();
        push(1'b1, 3, 1'b0); send_pkt(2'b11, 2'b11, 32'b101, 3, 0, 1'b1); drain();
        push(1'b1, 3, 1'b0); send_pkt(2'b10, 2'b10, 32'b111, 3, 0, 1'b1); drain();
        push(1'b0, 2, 1'b0); send_pkt(2'b10, 2'b10, 32'b11, 2, 0, 1'b1); drain();
        push(1'b0, 5, 1'b0); send_pkt(2'b01, 2'b00, 32'b00000, 5, 2, 1'b1); drain();
        push(1'b1, 3, 1'b0); send_pkt(2'b01, 2'b00, 32'b010, 3, 2, 1'b1); drain();
        push(1'b0, 3, 1'b0); send_pkt(2'b11, 2'b01, 32'b111, 3, 1, 1'b1); drain();

        // Result held with downstream stalled; a beat offered meanwhile must be refused.
        bus.down_ready = 1'b0;
        push(1'b1, 1, 1'b0);
        send_pkt(2'b00, 2'b00, 32'b1, 1, 0, 1'b1);
        bus.up_valid = 1'b1;
        bus.up_data  = 1'b0;
        bus.up_last  = 1'b1;
        bus.op       = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.down_valid), 32'd1);
            check("hold_up_ready", 32'(bus.up_ready), 32'd0);
            check("hold_result", 32'(bus.down_result), 32'd1);
            check("hold_count", 32'(bus.down_count), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.up_valid   = 1'b0;
        bus.up_last    = 1'b0;
        bus.down_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("release_up_ready", 32'(bus.up_ready), 32'd1);
        check("release_down_valid", 32'(bus.down_valid), 32'd0);
        drain();

        push(1'b1, 16, 1'b1); send_pkt(2'b01, 2'b01, 32'h1 << 17, 20, 0, 1'b1); drain();
        push(1'b0, 16, 1'b0); send_pkt(2'b00, 2'b00, 32'hFFFE, 16, 0, 1'b1); drain();

        // Reset mid-packet discards it; the monitor flags any stray result.
        send_pkt(2'b00, 2'b00, 32'b111, 3, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_down_valid", 32'(bus.down_valid), 32'd0);
        check("midrst_up_ready", 32'(bus.up_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(bus.down_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        push(1'b1, 2, 1'b0); send_pkt(2'b00, 2'b00, 32'b11, 2, 0, 1'b1); drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
